satd_accumulator: RTL
=====================

# satd_accumulator

Downstream stage of the vertical-Hadamard absolute-sum block. It accumulates the per-beat partial absolute sums (`sum_partial`) of one transformed block into a single SATD value. It then applies the size-dependent rounding normalisation and presents the result on a valid/ready output port. It is the last arithmetic stage before the SATD cost leaves the transform datapath.

## Interface
Parameters:
- `LENGTH`, 11: MSB index of the horizontal-transform samples; input partial width is `LENGTH+8` bits.
- `WIDTH`, 8: block width in samples.
- `HEIGHT`, 8: block height in samples.
- Derived `BEATS = WIDTH*HEIGHT/8`: partials per block. Derived `CNT_W = clog2(BEATS)`. Derived `ACC_W = LENGTH+8+CNT_W`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `clear`, in, 1: synchronous abort; drops the block in progress.
- `sel`, in, 1: transform-size select, sampled on the first beat of a block. 0 = 4x4 rounding, 1 = 8x8 rounding.
- `in_valid`, in, 1: `sum_partial` valid.
- `in_ready`, out, 1: accumulator can accept a partial.
- `sum_partial`, in, `LENGTH+8`: unsigned partial absolute sum.
- `satd`, out, `ACC_W`: normalised SATD of the completed block.
- `satd_valid`, out, 1: `satd` valid.
- `satd_ready`, in, 1: consumer accepts `satd`.
- `blk_count`, out, 16: number of completed blocks accepted by the consumer; wraps 0xFFFF→0.

## Operation
- The FSM has three states: IDLE, ACCUM, HOLD.
- A beat is accepted when `in_valid & in_ready`.
- `in_ready = (state != HOLD)`.
- IDLE: on an accepted beat, `acc <= sum_partial`, `beat_cnt <= 1`, `sel_q <= sel`, then go to ACCUM. If `BEATS==1`, go directly to HOLD.
- ACCUM: on an accepted beat, `acc <= acc + sum_partial` and `beat_cnt++`. When the accepted beat is beat `BEATS` (`beat_cnt == BEATS-1`), register the rounded result into `satd` and go to HOLD. Cycles with `in_valid=0` are bubbles with no effect.
- HOLD: `satd_valid=1`, and `satd` is stable. On `satd_ready=1`: `blk_count++`, go to IDLE. The next block's first beat is accepted no earlier than the following cycle.
- Rounding is computed on the full-width sum, with no truncation before the shift:
  - `sel_q=0`: `satd = (sum+1)>>1`.
  - `sel_q=1`: `satd = (sum+2)>>2`.
- `ACC_W` bits hold the worst case `BEATS*(2^(LENGTH+8)-1)` without overflow. No saturation logic is needed.
- `clear` has priority over everything except reset. From any state it goes to IDLE and zeroes `acc` and `beat_cnt`. A pending `satd` is discarded (`satd_valid` low next cycle). `blk_count` is unchanged.
- `sel` changes mid-block are ignored; only `sel_q` is used.

## Timing
- Reset values: state=IDLE, `in_ready=1`, `satd=0`, `satd_valid=0`, `blk_count=0`, internal `acc=0`, `beat_cnt=0`.
- Latency: `satd_valid` rises on the clock edge after the last beat is accepted (1 cycle).
- Throughput: at most one block per `BEATS+1` cycles, because of the HOLD/IDLE turnaround.
- Backpressure: while `satd_ready=0`, `satd`/`satd_valid` hold and `in_ready=0`. The upstream stage must stall.
- Reset asserted mid-block or in HOLD: all outputs return to their reset values immediately (asynchronous). No partial result is emitted.
- `clear` and the final beat in the same cycle: `clear` wins; no result is produced.
- `clear` and `satd_ready` in HOLD in the same cycle: `clear` wins; `blk_count` is not incremented.

## Structure
- Shared package `satd_pkg` holds:
  - the FSM state typedef `acc_state_t` (IDLE/ACCUM/HOLD);
  - the `clog2` function;
  - the rounding constants (`RND_4X4=1`, `SH_4X4=1`, `RND_8X8=2`, `SH_8X8=2`).
- One sub-module, `satd_round`: a combinational `ACC_W`-bit add-and-shift selected by `sel_q`. It is reused by the future 16x16 cost path.
- Everything else (FSM, counters, accumulator register) lives in `satd_accumulator`.

## Test plan
- 8 contiguous beats of 100, `sel=1` → `satd=200` one cycle after the 8th beat; `blk_count` 0→1 on acceptance.
- Same stimulus with `sel=0` → `satd=400`. Toggling `sel` to 1 after beat 1 must still give 400.
- 8 beats of `2^19-1` (LENGTH=11), `sel=0` → `satd=2097148`; `sel=1` → `satd=1048574`. Verifies no overflow.
- Beats interleaved with random `in_valid` gaps, then `satd_ready` held low 3 cycles → `satd` stable, `in_ready=0` throughout, exactly one `blk_count` increment.
- 3 beats of 500, then `clear`, then 8 beats of 1 with `sel=1` → `satd=2`; no result for the aborted block.
- `rst_n` pulsed low during beat 5 and again during HOLD → all outputs at reset values asynchronously; the next full block of 8×10 with `sel=1` gives `satd=20`.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared types and constants for the SATD accumulation stage.
// Holds the accumulator FSM states and the rounding constants.
package satd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

    localparam int RND_4X4 = 1;
    localparam int SH_4X4  = 1;
    localparam int RND_8X8 = 2;
    localparam int SH_8X8  = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/satd_round.sv
// Size-dependent rounding normalisation of an accumulated SATD sum.
// One extra bit on the bias add so the full-width sum never wraps.
module satd_round
    import satd_pkg::*;
#(
    parameter int ACC_W = 22
) (
    input  logic [ACC_W-1:0] sum,
    input  logic             sel,
    output logic [ACC_W-1:0] res
);

    logic [ACC_W:0] biased;

    always_comb begin
        biased = {1'b0, sum}
               + (sel ? (ACC_W+1)'(RND_8X8) : (ACC_W+1)'(RND_4X4));
        res = ACC_W'(sel ? (biased >> SH_8X8) : (biased >> SH_4X4));
    end

endmodule

// File: rtl/satd_accumulator.sv
// Accumulates per-beat partial absolute sums into one SATD per block
// and hands the rounded result out on a valid/ready port.
module satd_accumulator
    import satd_pkg::*;
#(
    parameter  int LENGTH = 11,
    parameter  int WIDTH  = 8,
    parameter  int HEIGHT = 8,
    localparam int BEATS  = WIDTH * HEIGHT / 8,
    localparam int CNT_W  = clog2(BEATS),
    localparam int PW     = LENGTH + 8,
    localparam int ACC_W  = LENGTH + 8 + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    sum_partial,
    output logic [ACC_W-1:0] satd,
    output logic             satd_valid,
    input  logic             satd_ready,
    output logic [15:0]      blk_count
);

    localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    acc_state_t       state_q;
    acc_state_t       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_next;
    logic [ACC_W-1:0] rnd;
    logic [CW-1:0]    cnt_q;
    logic             sel_q;
    logic             rsel;
    logic             accept;
    logic             last;
    logic             idle;

    assign idle       = (state_q == IDLE);
    assign in_ready   = (state_q != HOLD);
    assign satd_valid = (state_q == HOLD);
    assign accept     = in_valid & in_ready;
    assign last       = idle ? (BEATS == 1) : (cnt_q == LAST);
    assign sum_next   = (idle ? '0 : acc_q) + ACC_W'(sum_partial);
    // First beat rounds with the live select; later beats use the latched one
    assign rsel       = idle ? sel : sel_q;

    satd_round #(
        .ACC_W(ACC_W)
    ) u_round (
        .sum(sum_next),
        .sel(rsel),
        .res(rnd)
    );

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = last ? HOLD : ACCUM;
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (satd_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            satd      <= '0;
            blk_count <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                if (accept) begin
                    acc_q <= sum_next;
                    cnt_q <= last ? '0 : (idle ? CW'(1) : cnt_q + 1'b1);
                    if (idle) sel_q <= sel;
                    if (last) satd <= rnd;
                end
                if (satd_valid && satd_ready) blk_count <= blk_count + 16'd1;
            end
        end
    end

endmodule
